// File: rtl/el2_pmp_scan_ctl.sv
`default_nettype none
// ============================================================================
// Module   : el2_pmp_scan_ctl
// Purpose  : Shared, beat-serial PMP checker arbitrating LSU/IFU requests.
//            Define PMP_SCAN_EARLY_EXIT_EN to stop at the first matching beat.
// Revision : 1.0
// ============================================================================

package el2_pmp_scan_pkg;
  localparam logic [1:0] PMP_OFF   = 2'd0;
  localparam logic [1:0] PMP_TOR   = 2'd1;
  localparam logic [1:0] PMP_NA4   = 2'd2;
  localparam logic [1:0] PMP_NAPOT = 2'd3;

  typedef struct packed {
    logic       lock;
    logic [1:0] reserved;
    logic [1:0] mode;
    logic       execute;
    logic       write;
    logic       read;
  } el2_pmp_cfg_pkt_t;
endpackage

module el2_pmp_scan_ctl
  import el2_pmp_scan_pkg::*;
#(
  parameter int PMP_ENTRIES      = 16,
  parameter int ENTRIES_PER_BEAT = 4
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  el2_pmp_cfg_pkt_t               pmp_pmpcfg  [PMP_ENTRIES],
  input  logic [31:0]                    pmp_pmpaddr [PMP_ENTRIES],
  input  logic                           pmp_cfg_wr,
  input  logic [1:0]                     req_valid,
  output logic [1:0]                     req_ready,
  input  logic [31:0]                    req_addr    [2],
  input  logic [1:0]                     req_acc     [2],
  input  logic [1:0]                     req_mmode,
  output logic [1:0]                     rsp_valid,
  output logic                           rsp_err,
  output logic [$clog2(PMP_ENTRIES)-1:0] rsp_idx,
  output logic                           pmp_busy
);
  localparam int c_beats = PMP_ENTRIES / ENTRIES_PER_BEAT;
  localparam int c_bw    = (c_beats > 1) ? $clog2(c_beats) : 1;
  localparam int c_ew    = $clog2(PMP_ENTRIES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic              rr_q, id_q, mmode_q, found_q, err_q;
  logic [1:0]        acc_q;
  logic [31:0]       addr_q;
  logic [c_bw-1:0]   beat_q;
  logic [c_ew-1:0]   idx_q;
  logic [1:0]        rsp_valid_q;
  logic              rsp_err_q;
  logic [c_ew-1:0]   rsp_idx_q;

  logic              w_gnt_id;
  logic [1:0]        w_grant;

  always_comb begin
    w_gnt_id = (req_valid == 2'b11) ? rr_q : req_valid[1];
    w_grant  = 2'b00;
    if (state_q == S_IDLE && req_valid != 2'b00) w_grant = 2'b01 << w_gnt_id;
  end

  assign req_ready = w_grant;
  assign pmp_busy  = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_idx   = rsp_idx_q;

  logic [33:0]                 w_addr34;
  logic [ENTRIES_PER_BEAT-1:0] w_lane_hit, w_lane_allow;
  logic [c_ew-1:0]             w_lane_idx [ENTRIES_PER_BEAT];

  assign w_addr34 = {2'b00, addr_q};

  // Only ENTRIES_PER_BEAT comparators exist; the beat counter steers live CSR state into them.
  for (genvar j = 0; j < ENTRIES_PER_BEAT; j++) begin : g_lane
    el2_pmp_cfg_pkt_t l_cfg;
    logic [33:0]      l_hi, l_lo, l_pa, l_ign;
    logic             l_hit, l_perm;
    logic             l_unused_rsvd;

    assign w_lane_idx[j] = c_ew'(int'(beat_q) * ENTRIES_PER_BEAT + j);
    assign l_cfg         = pmp_pmpcfg[w_lane_idx[j]];
    assign l_hi          = {pmp_pmpaddr[w_lane_idx[j]], 2'b00};
    assign l_lo          = (w_lane_idx[j] == '0) ? 34'd0 :
                           {pmp_pmpaddr[w_lane_idx[j] - c_ew'(1)], 2'b00};
    assign l_pa          = {pmp_pmpaddr[w_lane_idx[j]], 2'b11};
    // Bits up to and including the first zero of the NAPOT encoding are don't-care.
    assign l_ign         = l_pa ^ (l_pa + 34'd1);
    assign l_unused_rsvd = ^l_cfg.reserved;

    always_comb begin
      l_hit  = 1'b0;
      l_perm = 1'b0;
      case (l_cfg.mode)
        PMP_TOR:   l_hit = (w_addr34 >= l_lo) && (w_addr34 < l_hi);
        PMP_NA4:   l_hit = (addr_q[31:2] == l_hi[31:2]);
        PMP_NAPOT: l_hit = (((w_addr34 ^ l_pa) & ~l_ign) == 34'd0);
        default:   l_hit = 1'b0;
      endcase
      case (acc_q)
        2'd0:    l_perm = l_cfg.read;
        2'd1:    l_perm = l_cfg.write;
        2'd2:    l_perm = l_cfg.execute;
        default: l_perm = 1'b0;
      endcase
    end

    assign w_lane_hit[j]   = l_hit;
    assign w_lane_allow[j] = (acc_q != 2'd3) && ((mmode_q && !l_cfg.lock) || l_perm);
  end

  logic            w_beat_hit, w_beat_allow, w_last, w_term, w_fin_err;
  logic [c_ew-1:0] w_beat_idx, w_fin_idx;

  always_comb begin
    w_beat_hit   = 1'b0;
    w_beat_allow = 1'b0;
    w_beat_idx   = '0;
    for (int j = ENTRIES_PER_BEAT - 1; j >= 0; j--) begin
      if (w_lane_hit[j]) begin
        w_beat_hit   = 1'b1;
        w_beat_allow = w_lane_allow[j];
        w_beat_idx   = w_lane_idx[j];
      end
    end
  end

  assign w_last = (beat_q == c_bw'(c_beats - 1));
`ifdef PMP_SCAN_EARLY_EXIT_EN
  assign w_term = w_last || w_beat_hit;
`else
  assign w_term = w_last;
`endif

  assign w_fin_err = found_q    ? err_q         :
                     w_beat_hit ? ~w_beat_allow :
                                  (~mmode_q || acc_q == 2'd3);
  assign w_fin_idx = found_q ? idx_q : (w_beat_hit ? w_beat_idx : '0);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      id_q        <= 1'b0;
      mmode_q     <= 1'b0;
      found_q     <= 1'b0;
      err_q       <= 1'b0;
      acc_q       <= 2'd0;
      addr_q      <= 32'd0;
      beat_q      <= '0;
      idx_q       <= '0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_idx_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_grant != 2'b00) begin
            id_q    <= w_gnt_id;
            addr_q  <= req_addr[w_gnt_id];
            acc_q   <= req_acc[w_gnt_id];
            mmode_q <= req_mmode[w_gnt_id];
            rr_q    <= ~w_gnt_id;
            beat_q  <= '0;
            found_q <= 1'b0;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (pmp_cfg_wr) begin
            beat_q  <= '0;
            found_q <= 1'b0;
          end else if (w_term) begin
            rsp_valid_q <= 2'b01 << id_q;
            rsp_err_q   <= w_fin_err;
            rsp_idx_q   <= w_fin_idx;
            state_q     <= S_RESP;
          end else begin
            beat_q <= beat_q + c_bw'(1);
            if (!found_q && w_beat_hit) begin
              found_q <= 1'b1;
              err_q   <= ~w_beat_allow;
              idx_q   <= w_beat_idx;
            end
          end
        end
        S_RESP: begin
          rsp_valid_q <= 2'b00;
          rsp_err_q   <= 1'b0;
          rsp_idx_q   <= '0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_el2_pmp_scan_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_el2_pmp_scan_ctl
// Purpose  : Directed self-checking bench for el2_pmp_scan_ctl (16 entries, 4/beat).
// Revision : 1.0
// ============================================================================
module tb_el2_pmp_scan_ctl;
  import el2_pmp_scan_pkg::*;

`ifdef PMP_SCAN_EARLY_EXIT_EN
  localparam bit c_ee = 1'b1;
`else
  localparam bit c_ee = 1'b0;
`endif

  logic             clk;
  logic             rst_l;
  el2_pmp_cfg_pkt_t pmpcfg  [16];
  logic [31:0]      pmpaddr [16];
  logic             pmp_cfg_wr;
  logic [1:0]       req_valid, req_ready, req_mmode, rsp_valid;
  logic [31:0]      req_addr [2];
  logic [1:0]       req_acc  [2];
  logic             rsp_err, pmp_busy;
  logic [3:0]       rsp_idx;

  int checks = 0;
  int errors = 0;

  bit         got;
  int         lat;
  logic [1:0] vld, rdy;
  logic       err;
  logic [3:0] idx;

  el2_pmp_scan_ctl #(.PMP_ENTRIES(16), .ENTRIES_PER_BEAT(4)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .pmp_pmpcfg (pmpcfg),
    .pmp_pmpaddr(pmpaddr),
    .pmp_cfg_wr (pmp_cfg_wr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_acc    (req_acc),
    .req_mmode  (req_mmode),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_idx    (rsp_idx),
    .pmp_busy   (pmp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic clear_cfg();
    for (int i = 0; i < 16; i++) begin
      pmpcfg[i]  = '0;
      pmpaddr[i] = 32'd0;
    end
  endtask

  task automatic set_entry(input int i, input logic [1:0] mode, input logic l, input logic x,
                           input logic w, input logic r, input logic [31:0] a);
    pmpcfg[i].lock     = l;
    pmpcfg[i].reserved = 2'b00;
    pmpcfg[i].mode     = mode;
    pmpcfg[i].execute  = x;
    pmpcfg[i].write    = w;
    pmpcfg[i].read     = r;
    pmpaddr[i]         = a;
  endtask

  // Issues one request and reports the first response seen, latency counted from the handshake cycle.
  task automatic run_req(input int id, input logic [31:0] a, input logic [1:0] acc, input logic mm,
                         output logic [1:0] o_rdy, output bit o_got, output int o_lat,
                         output logic [1:0] o_vld, output logic o_err, output logic [3:0] o_idx);
    @(negedge clk);
    req_addr[id]  = a;
    req_acc[id]   = acc;
    req_mmode[id] = mm;
    req_valid[id] = 1'b1;
    #1 o_rdy = req_ready;
    @(posedge clk);
    #1 req_valid = 2'b00;
    o_got = 1'b0; o_lat = 0; o_vld = 2'b00; o_err = 1'b0; o_idx = 4'd0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        o_got = 1'b1; o_lat = n; o_vld = rsp_valid; o_err = rsp_err; o_idx = rsp_idx;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_l = 1'b0; req_valid = 2'b00; pmp_cfg_wr = 1'b0; req_mmode = 2'b00;
    req_addr[0] = 32'd0; req_addr[1] = 32'd0; req_acc[0] = 2'd0; req_acc[1] = 2'd0;
    clear_cfg();
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_idx, pmp_busy} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b idx=%0d busy=%b, expected all 0",
               req_ready, rsp_valid, rsp_err, rsp_idx, pmp_busy);
    end
    rst_l = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, pmp_busy} !== 5'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got rdy=%b vld=%b busy=%b, expected 0", req_ready, rsp_valid, pmp_busy);
    end
  endtask

  task automatic test_napot();
    int el;
    el = c_ee ? 2 : 5;
    clear_cfg();
    set_entry(0, PMP_NAPOT, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_01FF);
    run_req(0, 32'h0000_0800, 2'd0, 1'b0, rdy, got, lat, vld, err, idx);
    checks++;
    if ({rdy, got, lat[7:0], vld, err, idx} !== {2'b01, 1'b1, 8'(el), 2'b01, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL napot_read: got rdy=%b got=%0b lat=%0d vld=%b err=%b idx=%0d, expected rdy=01 lat=%0d vld=01 err=0 idx=0",
               rdy, got, lat, vld, err, idx, el);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, pmp_busy} !== 3'b000) begin
      errors++;
      $display("FAIL rsp_pulse_width: got vld=%b busy=%b, expected 00 0", rsp_valid, pmp_busy);
    end
    run_req(0, 32'h0000_0800, 2'd1, 1'b0, rdy, got, lat, vld, err, idx);
    checks++;
    if ({got, lat[7:0], vld, err, idx} !== {1'b1, 8'(el), 2'b01, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL napot_write_locked: got lat=%0d vld=%b err=%b idx=%0d, expected lat=%0d vld=01 err=1 idx=0",
               lat, vld, err, idx, el);
    end
    pmpcfg[0].lock = 1'b0;
    run_req(0, 32'h0000_0800, 2'd1, 1'b1, rdy, got, lat, vld, err, idx);
    checks++;
    if ({got, vld, err, idx} !== {1'b1, 2'b01, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL napot_write_mmode: got got=%0b vld=%b err=%b idx=%0d, expected vld=01 err=0 idx=0", got, vld, err, idx);
    end
    run_req(0, 32'h0000_0800, 2'd3, 1'b1, rdy, got, lat, vld, err, idx);
    checks++;
    if ({got, err, idx} !== {1'b1, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL illegal_acc: got got=%0b err=%b idx=%0d, expected err=1 idx=0", got, err, idx);
    end
    run_req(0, 32'h0000_1000, 2'd0, 1'b1, rdy, got, lat, vld, err, idx);
    checks++;
    if ({got, lat[7:0], err, idx} !== {1'b1, 8'd5, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL nomatch_mmode: got lat=%0d err=%b idx=%0d, expected lat=5 err=0 idx=0", lat, err, idx);
    end
    run_req(0, 32'h0000_1000, 2'd0, 1'b0, rdy, got, lat, vld, err, idx);
    checks++;
    if ({got, lat[7:0], err, idx} !== {1'b1, 8'd5, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL nomatch_user: got lat=%0d err=%b idx=%0d, expected lat=5 err=1 idx=0", lat, err, idx);
    end
    set_entry(15, PMP_NAPOT, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3FFF_FFFF);
    run_req(0, 32'hFFFF_FFFC, 2'd0, 1'b0, rdy, got, lat, vld, err, idx);
    checks++;
    if ({got, lat[7:0], err, idx} !== {1'b1, 8'd5, 1'b0, 4'd15}) begin
      errors++;
      $display("FAIL napot_all_ones: got lat=%0d err=%b idx=%0d, expected lat=5 err=0 idx=15", lat, err, idx);
    end
  endtask

  task automatic test_na4_priority();
    int el;
    el = c_ee ? 4 : 5;
    clear_cfg();
    set_entry(9,  PMP_NA4,   1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0C00);
    set_entry(10, PMP_NAPOT, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0DFF);
    run_req(0, 32'h0000_3002, 2'd0, 1'b0, rdy, got, lat, vld, err, idx);
    checks++;
    if ({got, lat[7:0], err, idx} !== {1'b1, 8'(el), 1'b0, 4'd9}) begin
      errors++;
      $display("FAIL na4_low_wins: got lat=%0d err=%b idx=%0d, expected lat=%0d err=0 idx=9", lat, err, idx, el);
    end
    run_req(0, 32'h0000_3004, 2'd0, 1'b0, rdy, got, lat, vld, err, idx);
    checks++;
    if ({got, lat[7:0], err, idx} !== {1'b1, 8'(el), 1'b1, 4'd10}) begin
      errors++;
      $display("FAIL na4_miss_napot_hit: got lat=%0d err=%b idx=%0d, expected lat=%0d err=1 idx=10", lat, err, idx, el);
    end
  endtask

  task automatic test_tor();
    int el;
    el = c_ee ? 3 : 5;
    clear_cfg();
    set_entry(4, PMP_OFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0400);
    set_entry(5, PMP_TOR, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0800);
    run_req(1, 32'h0000_1000, 2'd2, 1'b0, rdy, got, lat, vld, err, idx);
    checks++;
    if ({rdy, got, lat[7:0], vld, err, idx} !== {2'b10, 1'b1, 8'(el), 2'b10, 1'b0, 4'd5}) begin
      errors++;
      $display("FAIL tor_lo_edge: got rdy=%b lat=%0d vld=%b err=%b idx=%0d, expected rdy=10 lat=%0d vld=10 err=0 idx=5",
               rdy, lat, vld, err, idx, el);
    end
    run_req(1, 32'h0000_1FFC, 2'd2, 1'b0, rdy, got, lat, vld, err, idx);
    checks++;
    if ({got, err, idx} !== {1'b1, 1'b0, 4'd5}) begin
      errors++;
      $display("FAIL tor_below_hi: got err=%b idx=%0d, expected err=0 idx=5", err, idx);
    end
    run_req(1, 32'h0000_2000, 2'd2, 1'b0, rdy, got, lat, vld, err, idx);
    checks++;
    if ({got, lat[7:0], vld, err, idx} !== {1'b1, 8'd5, 2'b10, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL tor_hi_excl: got lat=%0d vld=%b err=%b idx=%0d, expected lat=5 vld=10 err=1 idx=0", lat, vld, err, idx);
    end
    run_req(1, 32'h0000_0FFC, 2'd2, 1'b0, rdy, got, lat, vld, err, idx);
    checks++;
    if ({got, err, idx} !== {1'b1, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL tor_below_lo: got err=%b idx=%0d, expected err=1 idx=0", err, idx);
    end
    run_req(1, 32'h0000_1000, 2'd0, 1'b0, rdy, got, lat, vld, err, idx);
    checks++;
    if ({got, err, idx} !== {1'b1, 1'b1, 4'd5}) begin
      errors++;
      $display("FAIL tor_no_read_perm: got err=%b idx=%0d, expected err=1 idx=5", err, idx);
    end
    set_entry(0, PMP_TOR, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    run_req(0, 32'h0000_0000, 2'd0, 1'b0, rdy, got, lat, vld, err, idx);
    checks++;
    if ({got, lat[7:0], err, idx} !== {1'b1, 8'(c_ee ? 2 : 5), 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL tor_entry0: got lat=%0d err=%b idx=%0d, expected err=0 idx=0", lat, err, idx);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] bv [3];
    logic       be [3];
    int         bt [3];
    int         nr;
    for (int i = 0; i < 3; i++) begin bv[i] = 2'b00; be[i] = 1'b0; bt[i] = 0; end
    nr = 0;
    @(negedge clk); rst_l = 1'b0;
    @(negedge clk); rst_l = 1'b1;
    clear_cfg();
    set_entry(0, PMP_NAPOT, 1'b1, 1'b1, 1'b0, 1'b1, 32'h3FFF_FFFF);
    req_addr[0] = 32'h0000_0100; req_acc[0] = 2'd1;
    req_addr[1] = 32'h0000_0100; req_acc[1] = 2'd2;
    req_mmode = 2'b00;
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rr_first_grant: got rdy=%b, expected 01", req_ready);
    end
    for (int n = 1; n <= 40 && nr < 3; n++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        bv[nr] = rsp_valid; be[nr] = rsp_err; bt[nr] = n; nr++;
      end
    end
    req_valid = 2'b00;
    checks++;
    if ({bv[0], be[0], bv[1], be[1], bv[2], be[2]} !== {2'b01, 1'b1, 2'b10, 1'b0, 2'b01, 1'b1}) begin
      errors++;
      $display("FAIL rr_sequence: got %b/%b %b/%b %b/%b (n=%0d), expected 01/1 10/0 01/1",
               bv[0], be[0], bv[1], be[1], bv[2], be[2], nr);
    end
    checks++;
    if (bt[1] - bt[0] !== (c_ee ? 3 : 6)) begin
      errors++;
      $display("FAIL rr_spacing: got %0d cycles, expected %0d", bt[1] - bt[0], c_ee ? 3 : 6);
    end
    @(negedge clk);
    checks++;
    if ({pmp_busy, rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rr_drain_idle: got busy=%b vld=%b, expected 0 00", pmp_busy, rsp_valid);
    end
  endtask

  task automatic test_cfg_wr();
    int el;
    el = c_ee ? 5 : 7;
    clear_cfg();
    set_entry(5, PMP_NAPOT, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_01FF);
    @(negedge clk);
    req_addr[0] = 32'h0000_0800; req_acc[0] = 2'd0; req_mmode[0] = 1'b0; req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = 2'b00;
    got = 1'b0; lat = 0; vld = 2'b00; err = 1'b0; idx = 4'd0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        got = 1'b1; lat = n; vld = rsp_valid; err = rsp_err; idx = rsp_idx;
        break;
      end
      pmp_cfg_wr = (n == 2);
      if (n == 2) pmpcfg[5].read = 1'b1;
    end
    pmp_cfg_wr = 1'b0;
    checks++;
    if ({got, lat[7:0], vld, err, idx} !== {1'b1, 8'(el), 2'b01, 1'b0, 4'd5}) begin
      errors++;
      $display("FAIL cfg_wr_restart: got lat=%0d vld=%b err=%b idx=%0d, expected lat=%0d vld=01 err=0 idx=5",
               lat, vld, err, idx, el);
    end
    @(negedge clk); pmp_cfg_wr = 1'b1;
    @(negedge clk); pmp_cfg_wr = 1'b0;
    run_req(0, 32'h0000_0800, 2'd0, 1'b0, rdy, got, lat, vld, err, idx);
    checks++;
    if ({got, lat[7:0], err, idx} !== {1'b1, 8'(c_ee ? 3 : 5), 1'b0, 4'd5}) begin
      errors++;
      $display("FAIL cfg_wr_idle: got lat=%0d err=%b idx=%0d, expected err=0 idx=5", lat, err, idx);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    clear_cfg();
    @(negedge clk);
    req_addr[0] = 32'h0000_0800; req_acc[0] = 2'd0; req_mmode[0] = 1'b0; req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b0;
    @(negedge clk);
    checks++;
    if ({pmp_busy, rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_busy: got busy=%b vld=%b, expected 0 00", pmp_busy, rsp_valid);
    end
    rst_l = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_dropped: got %0d response cycles, expected 0", seen);
    end
    run_req(0, 32'h0000_0800, 2'd0, 1'b1, rdy, got, lat, vld, err, idx);
    checks++;
    if ({got, lat[7:0], vld, err, idx} !== {1'b1, 8'd5, 2'b01, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset_mid_fresh: got lat=%0d vld=%b err=%b idx=%0d, expected lat=5 vld=01 err=0 idx=0",
               lat, vld, err, idx);
    end
  endtask

  initial begin
    test_reset();
    test_napot();
    test_na4_priority();
    test_tor();
    test_back_to_back();
    test_cfg_wr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
